edge_detect_multi: RTL

- Parametrised multi-channel successor to the single-input edge tester.
- Each channel synchronises an asynchronous input, rejects glitches with a stable-count filter, and emits one-cycle rise/fall/any-edge pulses.
- Each channel keeps sticky rise/fall flags with per-channel clear, feeding a maskable interrupt.
- Sits between raw pins/status lines and control FSMs that need clean, single-cycle event strobes.

---
 rtl/edge_detect_multi_pkg.sv | 15 +
 rtl/edge_chan.sv | 109 ++++++++++
 rtl/edge_detect_multi.sv | 69 ++++++
 3 files changed

// File: rtl/edge_detect_multi_pkg.sv
// Shared types and default parameters for the multi-channel edge detector.
// Filter state encodings plus synchroniser/filter/counter default sizes.
package edge_detect_multi_pkg;

  typedef enum logic {
    ST_STABLE  = 1'b0,
    ST_PENDING = 1'b1
  } filt_st_e;

  localparam int SYNC_STAGES_DEF = 2;
  localparam int FILT_LEN_DEF    = 3;
  localparam int FILT_W_DEF      = 2;
  localparam int CNT_W_DEF       = 8;

endpackage

// File: rtl/edge_chan.sv
// One edge-detector channel: synchroniser, glitch filter, pulses, sticky flags.
// Optional saturating edge counter when EDGE_DETECT_CNT_EN is defined.
module edge_chan
  import edge_detect_multi_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int FILT_LEN    = FILT_LEN_DEF,
  parameter int FILT_W      = FILT_W_DEF
`ifdef EDGE_DETECT_CNT_EN
  ,
  parameter int CNT_W       = CNT_W_DEF
`endif
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  input  logic clr,
`ifdef EDGE_DETECT_CNT_EN
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] edge_cnt,
`endif
  output logic level,
  output logic rise,
  output logic fall,
  output logic any_edge,
  output logic rise_flag,
  output logic fall_flag
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [FILT_W-1:0]      cnt_q;
  filt_st_e               st_q;
  logic                   level_q;
  logic                   rise_q;
  logic                   fall_q;
  logic                   any_q;
  logic                   rflag_q;
  logic                   fflag_q;
  logic                   s;
  logic                   acc;

  assign s = sync_q[SYNC_STAGES-1];

  // Accept once s has disagreed with level for the full filter window.
  assign acc = (st_q == ST_PENDING) && (s != level_q) &&
               (cnt_q == FILT_W'(FILT_LEN - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q  <= '0;
      cnt_q   <= '0;
      st_q    <= ST_STABLE;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      any_q   <= 1'b0;
      rflag_q <= 1'b0;
      fflag_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], din};
      rise_q  <= acc & s;
      fall_q  <= acc & ~s;
      any_q   <= acc;
      rflag_q <= rise_q | (rflag_q & ~clr);
      fflag_q <= fall_q | (fflag_q & ~clr);
      unique case (st_q)
        ST_STABLE: begin
          cnt_q <= '0;
          if (s != level_q) st_q <= ST_PENDING;
        end
        ST_PENDING: begin
          if (s == level_q) begin
            st_q  <= ST_STABLE;
            cnt_q <= '0;
          end else if (acc) begin
            level_q <= s;
            st_q    <= ST_STABLE;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + FILT_W'(1);
          end
        end
        default: st_q <= ST_STABLE;
      endcase
    end
  end

`ifdef EDGE_DETECT_CNT_EN
  logic [CNT_W-1:0] ecnt_q;

  always_ff @(posedge clk) begin
    if (rst || cnt_clr) begin
      ecnt_q <= '0;
    end else if (acc && (ecnt_q != '1)) begin
      ecnt_q <= ecnt_q + CNT_W'(1);
    end
  end

  assign edge_cnt = ecnt_q;
`endif

  assign level     = level_q;
  assign rise      = rise_q;
  assign fall      = fall_q;
  assign any_edge  = any_q;
  assign rise_flag = rflag_q;
  assign fall_flag = fflag_q;

endmodule

// File: rtl/edge_detect_multi.sv
// Multi-channel edge detector top: CH edge_chan instances plus irq reduction.
// Define EDGE_DETECT_CNT_EN to add per-channel saturating edge counters.
module edge_detect_multi
  import edge_detect_multi_pkg::*;
#(
  parameter int CH          = 4,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int FILT_LEN    = FILT_LEN_DEF,
  parameter int FILT_W      = FILT_W_DEF
`ifdef EDGE_DETECT_CNT_EN
  ,
  parameter int CNT_W       = CNT_W_DEF
`endif
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [CH-1:0] din,
  input  logic [CH-1:0] clr,
  input  logic [CH-1:0] irq_en,
`ifdef EDGE_DETECT_CNT_EN
  input  logic [CH-1:0]       cnt_clr,
  output logic [CH*CNT_W-1:0] edge_cnt,
`endif
  output logic [CH-1:0] level,
  output logic [CH-1:0] rise,
  output logic [CH-1:0] fall,
  output logic [CH-1:0] any_edge,
  output logic [CH-1:0] rise_flag,
  output logic [CH-1:0] fall_flag,
  output logic          irq
);

  logic irq_q;

  for (genvar i = 0; i < CH; i++) begin : g_ch
    edge_chan #(
      .SYNC_STAGES (SYNC_STAGES),
      .FILT_LEN    (FILT_LEN),
      .FILT_W      (FILT_W)
`ifdef EDGE_DETECT_CNT_EN
      ,
      .CNT_W       (CNT_W)
`endif
    ) u_chan (
      .clk       (clk),
      .rst       (rst),
      .din       (din[i]),
      .clr       (clr[i]),
`ifdef EDGE_DETECT_CNT_EN
      .cnt_clr   (cnt_clr[i]),
      .edge_cnt  (edge_cnt[i*CNT_W +: CNT_W]),
`endif
      .level     (level[i]),
      .rise      (rise[i]),
      .fall      (fall[i]),
      .any_edge  (any_edge[i]),
      .rise_flag (rise_flag[i]),
      .fall_flag (fall_flag[i])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) irq_q <= 1'b0;
    else     irq_q <= |((rise_flag | fall_flag) & irq_en);
  end

  assign irq = irq_q;

endmodule
